// File: rtl/accum_shift_pkg.sv
// Shared mode encodings for the accumulate/shift register.
package accum_shift_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_LOAD  = 2'b01,
      MODE_ACCUM = 2'b10,
      MODE_SHIFT = 2'b11
   } mode_t;

endpackage

// File: rtl/accum_shift_reg_op_counter.sv
// Operation counter: counts executed operations and pulses count_wrap
// for one cycle after the count rolls over from all-ones to zero.
module op_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             sclr,
   input  logic             inc,
   output logic [CNT_W-1:0] op_count,
   output logic             count_wrap
);

   always_ff @(posedge clk) begin
      if (sclr) begin
         op_count   <= '0;
         count_wrap <= 1'b0;
      end else begin
         // The wrap pulse clears itself on any cycle that is not a rollover.
         count_wrap <= inc && (&op_count);
         if (inc) begin
            op_count <= op_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/accum_shift_reg.sv
// Accumulate/shift register with sticky overflow and operation counter.
// Define ACCUM_SAT_EN to saturate ACCUM results on carry instead of wrapping.
module accum_shift_reg
   import accum_shift_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHIFT = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             sclr,
   input  logic             clk_ena,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] datain,
   output logic [WIDTH-1:0] reg_out,
   output logic             ovf,
   output logic [CNT_W-1:0] op_count,
   output logic             count_wrap
);

   mode_t            op_mode;
   logic [WIDTH:0]   sum;
   logic             shift_spill;
   logic [WIDTH-1:0] next_reg;
   logic             next_ovf;
   logic             op_valid;

   assign op_mode  = mode_t'(mode);
   assign op_valid = clk_ena && (op_mode != MODE_HOLD);

   // Next register value and overflow; ovf is only ever set here, cleared by LOAD.
   always_comb begin
      sum         = {1'b0, reg_out} + {1'b0, datain};
      shift_spill = |reg_out[WIDTH-1 -: SHIFT];
      next_reg    = reg_out;
      next_ovf    = ovf;
      if (clk_ena) begin
         case (op_mode)
            MODE_LOAD: begin
               next_reg = datain;
               next_ovf = 1'b0;
            end
            MODE_ACCUM: begin
`ifdef ACCUM_SAT_EN
               if (sum[WIDTH]) begin
                  next_reg = '1;
                  next_ovf = 1'b1;
               end else begin
                  next_reg = sum[WIDTH-1:0];
               end
`else
               next_reg = sum[WIDTH-1:0];
               if (sum[WIDTH]) begin
                  next_ovf = 1'b1;
               end
`endif
            end
            MODE_SHIFT: begin
               next_reg = reg_out << SHIFT;
               if (shift_spill) begin
                  next_ovf = 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         reg_out <= '0;
         ovf     <= 1'b0;
      end else begin
         reg_out <= next_reg;
         ovf     <= next_ovf;
      end
   end

   op_counter #(
      .CNT_W(CNT_W)
   ) u_op_counter (
      .clk       (clk),
      .sclr      (sclr),
      .inc       (op_valid),
      .op_count  (op_count),
      .count_wrap(count_wrap)
   );

endmodule

// File: doc/accum_shift_reg.md
ACCUM_SHIFT_REG -- requirements
Module: accum_shift_reg

Interface
REQ-001 Parameter WIDTH, default 16: data and register width, legal range 4..64.
REQ-002 Parameter SHIFT, default 4: left-shift distance in SHIFT mode, legal range 1..WIDTH-1.
REQ-003 Parameter CNT_W, default 4: width of the operation counter.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port sclr  input  1: synchronous, active-high reset.
REQ-006 Port clk_ena  input  1: operation enable; when low, all state holds.
REQ-007 Port mode  input  2: 00 HOLD, 01 LOAD, 10 ACCUM, 11 SHIFT.
REQ-008 Port datain  input  WIDTH: operand for LOAD and ACCUM.
REQ-009 Port reg_out  output  WIDTH: registered register value.
REQ-010 Port ovf  output  1: sticky overflow flag.
REQ-011 Port op_count  output  CNT_W: count of executed non-HOLD operations.
REQ-012 Port count_wrap  output  1: one-cycle pulse when op_count wraps.

Function
REQ-013 All outputs are registered, with one-cycle latency from the sampled inputs to the outputs.
REQ-014 When clk_ena=0, reg_out, ovf and op_count hold, and count_wrap is 0 in the following cycle.
REQ-015 HOLD (00) with clk_ena=1: state holds; op_count does not increment.
REQ-016 LOAD (01): reg_out<=datain; ovf<=0.
REQ-017 ACCUM (10): reg_out<=(reg_out+datain) mod 2^WIDTH; ovf<=1 if the carry out of bit WIDTH-1 is 1, otherwise ovf holds.
REQ-018 SHIFT (11): reg_out<=reg_out<<SHIFT, zero-filled; ovf<=1 if any of the top SHIFT bits before the shift is 1, otherwise ovf holds.
REQ-019 Once set, ovf stays 1 until LOAD or sclr.
REQ-020 Each LOAD/ACCUM/SHIFT with clk_ena=1 increments op_count modulo 2^CNT_W.
REQ-021 count_wrap=1 for exactly the cycle after op_count goes from all-ones to 0; otherwise count_wrap=0.
REQ-022 sclr=1 has priority over clk_ena and mode, whatever their values.

Reset
REQ-023 On sclr=1 at a rising clk edge: reg_out=0, ovf=0, op_count=0, count_wrap=0.
REQ-024 An operation sampled in the same cycle as sclr=1 is discarded and has no effect.
REQ-025 sclr asserted mid-sequence: the next cycle after deassertion behaves as the first cycle from reset.

Configuration
REQ-026 Macro ACCUM_SAT_EN: when defined, an ACCUM that produces a carry sets reg_out to all-ones and sets ovf=1.
REQ-027 Without ACCUM_SAT_EN, ACCUM wraps modulo 2^WIDTH as per REQ-017.
REQ-028 ACCUM_SAT_EN does not affect SHIFT, LOAD or the counter.

Structure
REQ-029 Package accum_shift_pkg holds the mode encodings MODE_HOLD, MODE_LOAD, MODE_ACCUM and MODE_SHIFT, and the mode typedef.
REQ-030 Sub-module op_counter (CNT_W parameter) implements op_count and count_wrap; the datapath stays in accum_shift_reg.

Verification (WIDTH=16, SHIFT=4, CNT_W=4)
REQ-031 Sequence sclr=1 -> reg_out=0x0000, ovf=0, op_count=0; then LOAD 0x0F0F -> reg_out=0x0F0F, op_count=1.
REQ-032 After LOAD 0x0F0F: clk_ena=0 with mode=ACCUM and datain=0x1111 -> reg_out stays 0x0F0F; then sclr=1 with clk_ena=0 -> reg_out=0x0000.
REQ-033 LOAD 0xFFF0, then ACCUM 0x0020 -> reg_out=0x0010 and ovf=1 without the macro, or reg_out=0xFFFF and ovf=1 with ACCUM_SAT_EN; then LOAD 0x0001 -> ovf=0.
REQ-034 LOAD 0x1234, then SHIFT -> reg_out=0x2340, ovf=1; LOAD 0x0123, then SHIFT -> reg_out=0x1230, ovf=0.
REQ-035 16 consecutive LOADs from reset -> op_count returns to 0, and count_wrap=1 for exactly one cycle; HOLD cycles interleaved leave the count unchanged.
REQ-036 sclr=1 in the same cycle as ACCUM 0x0001 -> reg_out=0x0000, op_count=0, ovf=0.
